// File: rtl/muldiv_pkg.sv
// Shared types for the RV64M multiply/divide sequencer: op encoding, FSM states
// and a classifier that splits an op into W / divide / remainder / signedness traits.
package muldiv_pkg;

    localparam int MD_XLEN  = 64;
    localparam int MD_CNT_W = $clog2(MD_XLEN) + 1;

    typedef logic [MD_XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        MUL    = 4'd0,
        MULH   = 4'd1,
        MULHSU = 4'd2,
        MULHU  = 4'd3,
        DIV    = 4'd4,
        DIVU   = 4'd5,
        REM    = 4'd6,
        REMU   = 4'd7,
        MULW   = 4'd8,
        DIVW   = 4'd9,
        DIVUW  = 4'd10,
        REMW   = 4'd11,
        REMUW  = 4'd12
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    typedef struct packed {
        logic w;      // 32-bit op, result sign-extended from bit 31
        logic div;    // uses the shift-subtract datapath
        logic rem;    // returns the remainder rather than the quotient
        logic a_sgn;  // rs1 interpreted as signed
        logic b_sgn;  // rs2 interpreted as signed
    } op_class_t;

    function automatic op_class_t op_classify(input muldiv_op_t op);
        op_class_t c;
        c       = '0;
        c.w     = op inside {MULW, DIVW, DIVUW, REMW, REMUW};
        c.div   = op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
        c.rem   = op inside {REM, REMU, REMW, REMUW};
        c.a_sgn = op inside {MULH, MULHSU, DIV, REM, DIVW, REMW};
        c.b_sgn = op inside {MULH, DIV, REM, DIVW, REMW};
        return c;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iterative datapath: a 2*XLEN accumulator that performs one shift-add
// (multiply) or one restoring shift-subtract (divide) step per step_i pulse.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] init_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_nxt_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;

    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     sum, rem_sh, trial;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;

    always_comb begin
        hi      = acc_q[2*XLEN-1:XLEN];
        lo      = acc_q[XLEN-1:0];
        // multiply: multiplier drains out of lo, product builds from the top down
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {sum, lo[XLEN-1:1]};
        // divide: hi is the partial remainder, lo collects quotient bits at the bottom
        rem_sh  = {hi, lo[XLEN-1]};
        trial   = rem_sh - {1'b0, opnd_q};
        if (!trial[XLEN]) begin
            div_nxt = {trial[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end else begin
            div_nxt = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        end
        acc_nxt_o = is_div_q ? div_nxt : mul_nxt;
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        if (load_i) begin
            acc_d    = init_i;
            opnd_d   = opnd_i;
            is_div_d = is_div_i;
        end else if (step_i) begin
            acc_d    = acc_nxt_o;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// Sequencer for the shared iterative mul/div unit: stalls execute while the
// datapath iterates, resolves fast paths and sign/W fix-ups, and holds the result.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            advance,
    input  logic            flush,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    muldiv_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    muldiv_op_t        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   res_q, res_d;

    muldiv_op_t        op_in;
    op_class_t         cls_in, cls_q;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, fast_raw, fast_res;
    logic              a_neg, b_neg, div_zero, ovf, fast, neg_in;
    logic [2*XLEN-1:0] init_acc, acc_nxt, prod;
    logic [XLEN-1:0]   q_raw, r_raw, dv, dv_s, fin_res;
    logic [CNT_W-1:0]  last;
    logic              load, step;

    // Request decode: W ops see only the low word, extended per the op's signedness.
    always_comb begin
        op_in    = muldiv_op_t'(req_op);
        cls_in   = op_classify(op_in);
        a_ext    = cls_in.w ? (cls_in.a_sgn ? sext32(req_a[31:0]) : zext32(req_a[31:0])) : req_a;
        b_ext    = cls_in.w ? (cls_in.b_sgn ? sext32(req_b[31:0]) : zext32(req_b[31:0])) : req_b;
        a_neg    = cls_in.a_sgn & a_ext[XLEN-1];
        b_neg    = cls_in.b_sgn & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_val  = cls_in.w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = cls_in.div & (b_ext == '0);
        ovf      = cls_in.div & cls_in.a_sgn & (a_ext == min_val) & (b_ext == '1);
        fast     = div_zero | ovf;
        if (div_zero) begin
            fast_raw = cls_in.rem ? a_ext : '1;
        end else begin
            fast_raw = cls_in.rem ? '0 : a_ext;
        end
        fast_res = cls_in.w ? sext32(fast_raw[31:0]) : fast_raw;
        neg_in   = cls_in.rem ? a_neg : (a_neg ^ b_neg);
        // A 32-bit dividend starts at the top of lo so 32 steps consume all of it.
        if (cls_in.div && cls_in.w) begin
            init_acc = {{XLEN{1'b0}}, a_mag[31:0], {(XLEN-32){1'b0}}};
        end else begin
            init_acc = {{XLEN{1'b0}}, a_mag};
        end
    end

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load),
        .step_i    (step),
        .is_div_i  (cls_in.div),
        .init_i    (init_acc),
        .opnd_i    (b_mag),
        .acc_nxt_o (acc_nxt)
    );

    // Result formed from the accumulator value the final step is about to write.
    always_comb begin
        cls_q = op_classify(op_q);
        last  = cls_q.w ? CNT_W'(31) : CNT_W'(XLEN-1);
        prod  = neg_q ? -acc_nxt : acc_nxt;
        q_raw = cls_q.w ? zext32(acc_nxt[31:0]) : acc_nxt[XLEN-1:0];
        r_raw = cls_q.w ? zext32(acc_nxt[XLEN+31:XLEN]) : acc_nxt[2*XLEN-1:XLEN];
        dv    = cls_q.rem ? r_raw : q_raw;
        dv_s  = neg_q ? -dv : dv;
        if (cls_q.div) begin
            fin_res = cls_q.w ? sext32(dv_s[31:0]) : dv_s;
        end else if (op_q == MULW) begin
            // 32 right shifts leave the 64-bit product offset by XLEN-32
            fin_res = sext32(acc_nxt[XLEN-1:XLEN-32]);
        end else if (op_q == MUL) begin
            fin_res = prod[XLEN-1:0];
        end else begin
            fin_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        res_d   = res_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d  = op_in;
                    neg_d = neg_in;
                    if (fast) begin
                        state_d = DONE;
                        res_d   = fast_res;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == last) begin
                        state_d = DONE;
                        res_d   = fin_res;
                    end
                end
            end
            DONE: begin
                if (flush || advance) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MUL;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    assign stall      = ((state_q == IDLE) && req_valid && !flush) || (state_q == BUSY);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = res_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed plus randomized checks of muldiv_sched against an arithmetic reference model.
module tb_muldiv_sched;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        advance = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_data;

    int vecs = 0;
    int errs = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .advance    (advance),
        .flush      (flush),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic bit is_w_op(input muldiv_op_t op);
        return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic bit ref_fast(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            DIV, REM:     return (b == 64'd0) || (a == MIN64 && b == ONES);
            DIVU, REMU:   return (b == 64'd0);
            DIVW, REMW:   return (b[31:0] == 32'd0) || (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
            DIVUW, REMUW: return (b[31:0] == 32'd0);
            default:      return 1'b0;
        endcase
    endfunction

    function automatic int ref_lat(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b);
        if (ref_fast(op, a, b)) return 1;
        return is_w_op(op) ? 33 : 65;
    endfunction

    function automatic logic [63:0] ref_res(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       ua, ub, sa, sb, p;
        logic signed [63:0] s_a, s_b, sq;
        logic signed [31:0] w_a, w_b, wq;
        logic [31:0]        u_a, u_b, uq;
        ua  = {64'd0, a};
        ub  = {64'd0, b};
        sa  = {{64{a[63]}}, a};
        sb  = {{64{b[63]}}, b};
        s_a = a;
        s_b = b;
        u_a = a[31:0];
        u_b = b[31:0];
        w_a = u_a;
        w_b = u_b;
        case (op)
            MUL:    begin p = ua * ub; return p[63:0]; end
            MULH:   begin p = sa * sb; return p[127:64]; end
            MULHSU: begin p = sa * ub; return p[127:64]; end
            MULHU:  begin p = ua * ub; return p[127:64]; end
            DIV: begin
                if (b == 64'd0) return ONES;
                if (a == MIN64 && b == ONES) return a;
                sq = s_a / s_b;
                return sq;
            end
            REM: begin
                if (b == 64'd0) return a;
                if (a == MIN64 && b == ONES) return 64'd0;
                sq = s_a % s_b;
                return sq;
            end
            DIVU: return (b == 64'd0) ? ONES : a / b;
            REMU: return (b == 64'd0) ? a : a % b;
            MULW: begin uq = u_a * u_b; return sx32(uq); end
            DIVW: begin
                if (u_b == 32'd0) return ONES;
                if (u_a == 32'h8000_0000 && u_b == 32'hFFFF_FFFF) return sx32(u_a);
                wq = w_a / w_b;
                return sx32(wq);
            end
            DIVUW: return (u_b == 32'd0) ? ONES : sx32(u_a / u_b);
            REMW: begin
                if (u_b == 32'd0) return sx32(u_a);
                if (u_a == 32'h8000_0000 && u_b == 32'hFFFF_FFFF) return 64'd0;
                wq = w_a % w_b;
                return sx32(wq);
            end
            REMUW: return (u_b == 32'd0) ? sx32(u_a) : sx32(u_a % u_b);
            default: return 64'd0;
        endcase
    endfunction

    // Called right after a falling edge with the unit idle; leaves advance high
    // in the DONE cycle so the caller decides what follows.
    task automatic run_op(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp;
        int          lat;
        exp       = ref_res(op, a, b);
        lat       = ref_lat(op, a, b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        #1;
        chk1($sformatf("%s start stall", op.name()), stall, 1'b1);
        chk1($sformatf("%s start resp_valid", op.name()), resp_valid, 1'b0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                chk1($sformatf("%s busy stall c%0d", op.name(), k), stall, 1'b1);
                chk1($sformatf("%s busy resp_valid c%0d", op.name(), k), resp_valid, 1'b0);
            end
        end
        chk1($sformatf("%s done resp_valid", op.name()), resp_valid, 1'b1);
        chk1($sformatf("%s done stall", op.name()), stall, 1'b0);
        chk64($sformatf("%s %h,%h data", op.name(), a, b), resp_data, exp);
        for (int h = 0; h < hold; h++) begin
            req_a = {$urandom(), $urandom()};
            req_b = {$urandom(), $urandom()};
            @(negedge clk);
            chk1($sformatf("%s hold resp_valid h%0d", op.name(), h), resp_valid, 1'b1);
            chk64($sformatf("%s hold data h%0d", op.name(), h), resp_data, exp);
        end
        advance = 1'b1;
    endtask

    task automatic retire(input bit next_valid);
        req_valid = next_valid;
        #1;
        chk1("retire stall", stall, 1'b0);
        chk1("retire resp_valid", resp_valid, 1'b1);
        @(negedge clk);
        advance = 1'b0;
        #1;
        chk1("post-advance resp_valid", resp_valid, 1'b0);
        if (!next_valid) chk1("post-advance stall", stall, 1'b0);
    endtask

    function automatic logic [63:0] rand_word(input int kind);
        case (kind)
            0:       return {$urandom(), $urandom()};
            1:       return 64'($urandom_range(0, 40));
            2:       return -64'($urandom_range(1, 40));
            3:       return ($urandom_range(0, 1) != 0) ? MIN64 : ONES;
            4:       return sx32($urandom());
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        muldiv_op_t op;
        logic [63:0] a, b;

        // reset state
        #1;
        chk1("reset stall", stall, 1'b0);
        chk1("reset resp_valid", resp_valid, 1'b0);
        chk64("reset resp_data", resp_data, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_op(DIVU, 64'd100, 64'd7, 5);              retire(1'b0);
        run_op(REMU, 64'd100, 64'd7, 0);              retire(1'b0);
        run_op(REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0); retire(1'b0);
        run_op(DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0); retire(1'b0);
        run_op(DIV, 64'd5, 64'd0, 0);                 retire(1'b0);
        run_op(REM, 64'd5, 64'd0, 0);                 retire(1'b0);
        run_op(DIV, MIN64, ONES, 0);                  retire(1'b0);
        run_op(REM, MIN64, ONES, 0);                  retire(1'b0);
        run_op(MULHU, ONES, ONES, 0);                 retire(1'b0);
        run_op(MULW, 64'h7FFF_FFFF, 64'd2, 0);        retire(1'b0);
        run_op(DIVW, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 0); retire(1'b0);
        run_op(MULH, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0); retire(1'b0);
        run_op(MULHSU, ONES, ONES, 0);                retire(1'b0);
        run_op(DIVUW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 0); retire(1'b0);
        run_op(REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0); retire(1'b0);

        // back-to-back: advance cycle shows the bubble, next op starts a cycle later
        run_op(DIV, 64'd1000, 64'd33, 0);
        req_op = MUL; req_a = 64'd12345; req_b = 64'd678;
        retire(1'b1);
        run_op(MUL, 64'd12345, 64'd678, 0);           retire(1'b0);

        // flush in cycle 10 of a DIV, then a MUL two cycles later
        req_op = DIV; req_a = 64'd999_999; req_b = 64'd13; req_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk1($sformatf("flush-run stall c%0d", c), stall, 1'b1);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        chk1("after flush stall", stall, 1'b0);
        chk1("after flush resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        run_op(MUL, ONES, 64'd3, 0);                  retire(1'b0);

        // flush overrides a request in IDLE
        req_op = DIVU; req_a = 64'd50; req_b = 64'd0; req_valid = 1'b1; flush = 1'b1;
        #1;
        chk1("idle flush stall", stall, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        chk1("idle flush resp_valid", resp_valid, 1'b0);
        chk1("idle flush no busy", stall, 1'b0);

        // flush in DONE drops the response
        run_op(DIV, 64'd7, 64'd0, 0);
        advance = 1'b0;
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk1("done flush resp_valid", resp_valid, 1'b0);

        // randomized ops, sometimes chained back to back
        op = muldiv_op_t'($urandom_range(0, 12));
        a  = rand_word($urandom_range(0, 4));
        b  = rand_word($urandom_range(0, 4));
        for (int i = 0; i < 40; i++) begin
            run_op(op, a, b, $urandom_range(0, 2));
            op = muldiv_op_t'($urandom_range(0, 12));
            a  = rand_word($urandom_range(0, 4));
            b  = rand_word($urandom_range(0, 4));
            if ($urandom_range(0, 1) != 0) begin
                req_op = op; req_a = a; req_b = b;
                retire(1'b1);
            end else begin
                retire(1'b0);
            end
        end

        // async reset in the middle of an iterative op
        req_op = DIVU; req_a = ONES; req_b = 64'd3; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) @(negedge clk);
        #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk1("mid-busy reset stall", stall, 1'b0);
        chk1("mid-busy reset resp_valid", resp_valid, 1'b0);
        chk64("mid-busy reset resp_data", resp_data, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk1("post-reset resp_valid", resp_valid, 1'b0);
        chk1("post-reset stall", stall, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
